// File: rtl/pdm_pkg.sv
// Shared constants, state encoding and width helper for the PDM modulator.
package pdm_pkg;

   localparam int unsigned WIDTH_DEF       = 10;
   localparam int unsigned SAMPLE_BITS_DEF = 1024;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Width of a counter able to hold 0..sample_bits inclusive.
   function automatic int unsigned cnt_w(input int unsigned sample_bits);
      return $clog2(sample_bits) + 1;
   endfunction

   localparam int unsigned CNT_W = cnt_w(SAMPLE_BITS_DEF);

endpackage

// File: rtl/pdm_tick_gen.sv
// Bit-rate divider: pulses tick_c once every CLK_DIV enabled cycles, held at zero when disabled.
module pdm_tick_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic CLK100MHZ,
   input  logic ck_rst,
   input  logic clr,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned DIV_W = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   assign tick_c = en && (div_cnt == DIV_MAX);

   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst || clr || !en || tick_c) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pdm_modulator.sv
// First-order sigma-delta PDM modulator with per-window sample latching.
// Define PDM_DENSITY_MON_EN to build the ones-per-window density monitor; otherwise density is 0.
module pdm_modulator
   import pdm_pkg::*;
#(
   parameter int unsigned WIDTH       = WIDTH_DEF,
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF
) (
   input  logic                           CLK100MHZ,
   input  logic                           ck_rst,
   input  logic                           en,
   input  logic [WIDTH-1:0]               in_sig,
   output logic                           pdm_out,
   output logic                           bit_strobe,
   output logic                           sample_strobe,
   output logic [cnt_w(SAMPLE_BITS)-1:0]  density
);

   localparam int unsigned DW    = cnt_w(SAMPLE_BITS);
   localparam int unsigned BIT_W = DW - 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SAMPLE_BITS - 1);

   state_t             state;
   state_t             state_nxt;
   logic               tick_c;
   logic               load_c;
   logic               win_end_c;
   logic [WIDTH:0]     sum_c;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   sample_reg;
   logic [BIT_W-1:0]   bit_cnt;

   pdm_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .CLK100MHZ (CLK100MHZ),
      .ck_rst    (ck_rst),
      .clr       (load_c),
      .en        (state == ST_RUN),
      .tick_c    (tick_c)
   );

   // The carry out of the accumulator is the PDM bit.
   assign sum_c = {1'b0, acc} + {1'b0, sample_reg};

   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      win_end_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) begin
               state_nxt = ST_RUN;
               load_c    = 1'b1;
            end
         end
         ST_RUN: begin
            if (tick_c && (bit_cnt == LAST_BIT)) begin
               win_end_c = 1'b1;
               if (en) begin
                  load_c = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         pdm_out       <= 1'b0;
         bit_strobe    <= 1'b0;
         sample_strobe <= 1'b0;
         acc           <= '0;
         sample_reg    <= '0;
         bit_cnt       <= '0;
      end else begin
         bit_strobe    <= tick_c;
         sample_strobe <= load_c;
         if (load_c) begin
            sample_reg <= in_sig;
         end
         if (state == ST_IDLE) begin
            pdm_out <= 1'b0;
            acc     <= '0;
            bit_cnt <= '0;
         end else if (tick_c) begin
            pdm_out <= sum_c[WIDTH];
            acc     <= sum_c[WIDTH-1:0];
            bit_cnt <= win_end_c ? '0 : bit_cnt + 1'b1;
         end
      end
   end

`ifdef PDM_DENSITY_MON_EN
   logic [DW-1:0] ones_cnt;

   // Count ones per window; the window's last bit is folded in as density is published.
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         ones_cnt <= '0;
         density  <= '0;
      end else if (state == ST_IDLE) begin
         ones_cnt <= '0;
      end else if (tick_c) begin
         if (win_end_c) begin
            density  <= ones_cnt + DW'(sum_c[WIDTH]);
            ones_cnt <= '0;
         end else begin
            ones_cnt <= ones_cnt + DW'(sum_c[WIDTH]);
         end
      end
   end
`else
   assign density = '0;
`endif

endmodule

// File: tb/tb_pdm_modulator.sv
// Scoreboard bench for pdm_modulator: per-bit stream model, window densities, strobe timing.
module tb_pdm_modulator;

   localparam int unsigned WIDTH   = 10;
   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned SB      = 1024;
   localparam int unsigned DW      = 11;
`ifdef PDM_DENSITY_MON_EN
   localparam bit DENS_ON = 1'b1;
`else
   localparam bit DENS_ON = 1'b0;
`endif

   logic             CLK100MHZ = 1'b0;
   logic             ck_rst;
   logic             en;
   logic [WIDTH-1:0] in_sig;
   logic             pdm_out;
   logic             bit_strobe;
   logic             sample_strobe;
   logic [DW-1:0]    density;

   pdm_modulator #(
      .WIDTH       (WIDTH),
      .CLK_DIV     (CLK_DIV),
      .SAMPLE_BITS (SB)
   ) dut (
      .CLK100MHZ     (CLK100MHZ),
      .ck_rst        (ck_rst),
      .en            (en),
      .in_sig        (in_sig),
      .pdm_out       (pdm_out),
      .bit_strobe    (bit_strobe),
      .sample_strobe (sample_strobe),
      .density       (density)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Input values as the DUT saw them at the last rising edge.
   bit             last_rst = 1'b0;
   bit             last_en  = 1'b0;
   bit [WIDTH-1:0] last_in  = '0;
   always @(posedge CLK100MHZ) begin
      last_rst <= ck_rst;
      last_en  <= en;
      last_in  <= in_sig;
   end

   // Reference model: running total of samples; each multiple of 2**WIDTH crossed emits a one.
   bit     running    = 1'b0;
   bit     exp_pdm    = 1'b0;
   bit     prev_bs    = 1'b0;
   bit     prev_ss    = 1'b0;
   bit     going_idle = 1'b0;
   int     bits_in_win = 0;
   int     ones_win    = 0;
   int     gap         = 0;
   int     ss_gap      = 0;
   int     m_sample    = 0;
   int     exp_d       = 0;
   longint acc_t       = 0;
   longint nt          = 0;
   int     exp_q[$];

   always @(negedge CLK100MHZ) begin
      going_idle = 1'b0;
      if (last_rst) begin
         check_val("rst_pdm", pdm_out, 0);
         check_val("rst_bit_strobe", bit_strobe, 0);
         check_val("rst_sample_strobe", sample_strobe, 0);
         check_val("rst_density", density, 0);
         running = 1'b0;
         exp_pdm = 1'b0;
         exp_q.delete();
      end else if (running) begin
         gap++;
         ss_gap++;
         if (bit_strobe) begin
            check_val("bit_strobe_width", prev_bs, 0);
            check_val("bit_gap", gap, CLK_DIV);
            gap = 0;
            nt = acc_t + longint'(m_sample);
            exp_pdm = ((nt >> WIDTH) != (acc_t >> WIDTH));
            acc_t = nt;
            ones_win += int'(pdm_out);
            bits_in_win++;
            if (bits_in_win == SB) begin
               check_val("sb_size", exp_q.size(), 1);
               exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
               check_val("win_ones", ones_win, exp_d);
               check_val("density", density, DENS_ON ? exp_d : 0);
               check_val("ss_at_win_end", sample_strobe, last_en);
               if (sample_strobe) begin
                  check_val("ss_period", ss_gap, CLK_DIV * SB);
                  ss_gap   = 0;
                  m_sample = int'(last_in);
                  exp_q.push_back(int'(last_in));
               end else begin
                  going_idle = 1'b1;
               end
               bits_in_win = 0;
               ones_win    = 0;
            end else begin
               check_val("ss_mid_window", sample_strobe, 0);
            end
         end else begin
            check_val("ss_mid_window", sample_strobe, 0);
         end
         check_val("pdm_bit", pdm_out, exp_pdm);
         if (going_idle) begin
            running = 1'b0;
            exp_pdm = 1'b0;
         end
      end else begin
         check_val("idle_pdm", pdm_out, 0);
         check_val("idle_bit_strobe", bit_strobe, 0);
         check_val("idle_ss", sample_strobe, last_en);
         if (sample_strobe) begin
            check_val("ss_width", prev_ss, 0);
            running     = 1'b1;
            gap         = 0;
            ss_gap      = 0;
            acc_t       = 0;
            exp_pdm     = 1'b0;
            bits_in_win = 0;
            ones_win    = 0;
            m_sample    = int'(last_in);
            exp_q.push_back(int'(last_in));
         end
      end
      prev_bs = bit_strobe;
      prev_ss = sample_strobe;
   end

   // Inputs change just after the falling edge, after the model has updated.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge CLK100MHZ);
         #1;
      end
   endtask

   task automatic wait_bits(input int target, input string tag);
      int budget;
      budget = 0;
      while (!(running && bits_in_win == target) && budget < 6 * CLK_DIV * SB) begin
         step(1);
         budget++;
      end
      if (budget >= 6 * CLK_DIV * SB) check_val({tag, "_timeout"}, budget, 0);
   endtask

   int       cnt;
   int       budget;
   bit [3:0] pat;

   initial begin
      ck_rst = 1'b1;
      en     = 1'b0;
      in_sig = '0;
      step(3);
      ck_rst = 1'b0;
      step(10);

      // Mid-scale: alternating stream, density 512.
      in_sig = 10'd512;
      en     = 1'b1;
      pat    = '0;
      cnt    = 0;
      budget = 0;
      while (cnt < 4 && budget < 100) begin
         step(1);
         budget++;
         if (bit_strobe) begin
            pat = {pat[2:0], pdm_out};
            cnt++;
         end
      end
      check_val("mid_first_bits", pat, 4'b0101);
      step(CLK_DIV * SB + 50);

      // Reset mid-window, restart with a zero sample.
      wait_bits(200, "pre_reset");
      ck_rst = 1'b1;
      step(1);
      in_sig = '0;
      ck_rst = 1'b0;

      // Sample changes mid-window only take effect at the next window.
      wait_bits(500, "zero_win");
      in_sig = 10'd1023;
      wait_bits(500, "full_win");
      in_sig = 10'd100;
      wait_bits(500, "win100");
      in_sig = 10'd900;
      wait_bits(500, "win900");

      // Ramp from the wave generator.
      repeat (200) begin
         in_sig = in_sig + 10'd37;
         step(50);
      end

      // Graceful stop at bit 300 of a window.
      wait_bits(300, "stop");
      en     = 1'b0;
      cnt    = 0;
      budget = 0;
      while (running && budget < 2 * CLK_DIV * SB) begin
         step(1);
         budget++;
         if (bit_strobe) cnt++;
      end
      check_val("stop_tail_bits", cnt, SB - 300);
      step(300);
      check_val("stop_pdm", pdm_out, 0);
      check_val("stop_running", running, 0);
      check_val("stop_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pdm_modulator.md
Name: pdm_modulator

Overview:
- First-order sigma-delta (PDM) modulator directly downstream of the ramp/wave generator.
- Takes the generator's 10-bit unsigned sample `out_sig` on `in_sig`.
- Emits a 1-bit pulse-density stream at `CLK100MHZ`/`CLK_DIV` for the board output pin and external RC filter.
- Samples are latched once per fixed window of `SAMPLE_BITS` output bits, so the stream density tracks the input.

Parameters:
- WIDTH, 10: input sample width; accumulator is WIDTH+1 bits.
- CLK_DIV, 4: system clocks per PDM bit (≥2); 4 gives 25 MHz bit rate.
- SAMPLE_BITS, 1024: PDM bits per sample window; must equal 2**WIDTH for the exact-density guarantee.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz, all logic on its rising edge.
- ck_rst  input  1  synchronous, active-high reset.
- en  input  1  run request; level-sensitive.
- in_sig  input  WIDTH  unsigned sample from wave generator; sampled only at window loads.
- pdm_out  output  1  registered PDM bit stream.
- bit_strobe  output  1  one-cycle pulse coincident with each new pdm_out value.
- sample_strobe  output  1  one-cycle pulse in the cycle after in_sig was latched.
- density  output  $clog2(SAMPLE_BITS)+1  count of ones in the last completed window (monitor option).

Behaviour:
- Reset (ck_rst=1 at an edge): state=IDLE, div_cnt=0, bit_cnt=0, acc=0, sample_reg=0, ones_cnt=0. All outputs 0. Reset overrides everything, including mid-window; the partial window is discarded.
- tick: internal, true when state=RUN and div_cnt==CLK_DIV-1. div_cnt wraps to 0 on tick and holds at 0 in IDLE.
- IDLE:
  - pdm_out=0, acc held at 0.
  - If en=1: go to RUN next edge, load sample_reg<=in_sig, pulse sample_strobe, clear div_cnt, bit_cnt and ones_cnt.
  - The first tick occurs CLK_DIV cycles after entering RUN.
- RUN, on each tick:
  - sum = {1'b0, acc[WIDTH-1:0]} + sample_reg (WIDTH+1 bits, no overflow).
  - pdm_out<=sum[WIDTH]; acc<=sum with the carry bit dropped; bit_strobe<=1 for that one cycle.
  - ones_cnt increments when sum[WIDTH]=1.
- RUN, window end (tick with bit_cnt==SAMPLE_BITS-1):
  - bit_cnt<=0; density<=ones_cnt plus the current bit; ones_cnt<=0.
  - If en=1: sample_reg<=in_sig and pulse sample_strobe.
  - If en=0: go to IDLE; pdm_out is forced 0 from the following edge.
  - Otherwise bit_cnt increments.
- en deasserted mid-window: the window completes (no truncation), then IDLE. en reasserted before the window end: treated as continuous RUN.
- Invariant: with SAMPLE_BITS=2**WIDTH, every completed window has exactly sample_reg ones, regardless of starting acc.
  - in_sig=0 gives all zeros.
  - in_sig=1023 gives 1023 ones per 1024 bits.
- pdm_out holds its value between ticks. bit_strobe and sample_strobe are never high for more than one cycle.

Optional Feature:
- Macro: PDM_DENSITY_MON_EN.
- Defined: ones_cnt and the density register are implemented as described above.
- Undefined: no ones_cnt or density register; density is tied to 0. pdm_out, the strobes and timing are identical in both builds.

Decomposition:
- Package pdm_pkg holds:
  - the WIDTH default;
  - the state encoding constants ST_IDLE and ST_RUN;
  - the helper CNT_W = $clog2(SAMPLE_BITS)+1.
- One sub-module: pdm_tick_gen, the CLK_DIV divider with clear and enable, producing tick.
- The modulator core and FSM stay in pdm_modulator.

Test Plan:
- Reset behaviour: pulse ck_rst while RUN, mid-window → next edge pdm_out=0, strobes 0, density=0, state IDLE; after en=1, the first bit_strobe comes CLK_DIV cycles after sample_strobe.
- Mid-scale sample: en=1, in_sig=512 → pdm_out sequence 0,1,0,1…; bit_strobe every 4 cycles; density=512 after the first window.
- Extreme samples:
  - in_sig=0 → pdm_out stays 0 for a full window, density=0.
  - in_sig=1023 → exactly one 0 per 1024 bits, density=1023.
- Sample update at window boundary: in_sig=100 for window 1, changed to 900 mid-window 1 → density 100 for window 1 and 900 for window 2; sample_strobe once per 4096 cycles.
- Graceful stop: drop en at bit 300 of a window → 724 further bit_strobes occur, then IDLE with pdm_out=0 and no further sample_strobe.
- Wave generator ramp: drive in_sig from the wave generator ramp → each window's density equals the in_sig value latched at its start; also build without PDM_DENSITY_MON_EN and check density==0 with an identical pdm_out trace.
